// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite types and helpers.
//   axil_resp_t     - 2-bit AXI response code.
//   addr_in_window  - true when addr lies in [base, base+span). Arguments are
//                     zero-extended to 64 bits by the caller, and the upper bound
//                     is computed with a carry bit so a window that reaches the
//                     top of the address space does not wrap.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  function automatic logic addr_in_window(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input logic [63:0] span);
    logic [64:0] limit;
    limit = {1'b0, base} + {1'b0, span};
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and count-based flags.
//   clk_i        clock
//   rst_i        synchronous active-high flush
//   push_i       write request; ignored while full, even if popping this cycle
//   push_data_i  write data
//   pop_i        read request; ignored while empty
//   head_o       oldest entry (valid when !empty_o), read straight from storage
//   full_o       DEPTH entries held
//   empty_o      no entries held
// DEPTH must be a power of 2 so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    // Contents need no reset: the pointers and count decide what is valid.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axil2reg_wr_q.sv
// axil2reg_wr_q: queued AXI4-Lite write slave driving a register-write port.
//   clk, rst             clock; synchronous active-high reset flushing all FIFOs
//   s_axil_aw*           AW channel, buffered in an AW_DEPTH FIFO (awprot ignored)
//   s_axil_w*            W channel, buffered in a W_DEPTH FIFO
//   s_axil_b*            B channel, served from a B_DEPTH response FIFO
//   reg_wr_*             register write request, held until reg_wr_ready;
//                        reg_wr_okay is the status sampled on acceptance
// AW and W heads pair in arrival order. A pair is issued only when the B FIFO
// has room; out-of-window pairs complete as DECERR, misaligned ones as SLVERR,
// both without touching the register side.
module axil2reg_wr_q
  import axil_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned          AW_DEPTH   = 4,
  parameter int unsigned          W_DEPTH    = 4,
  parameter int unsigned          B_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_WIDTH:0]   ADDR_SPAN = (ADDR_WIDTH + 1)'('h1000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_ready,
  input  logic                  reg_wr_okay
);

  localparam int unsigned WFifoW = DATA_WIDTH + STRB_WIDTH;
  // Low address bits that must be zero for a bus-width-aligned access.
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(STRB_WIDTH - 1);

  logic [ADDR_WIDTH-1:0] aw_head;
  logic                  aw_full, aw_empty, aw_push;
  logic [WFifoW-1:0]     w_head;
  logic                  w_full, w_empty, w_push;
  logic [1:0]            b_head;
  logic                  b_full, b_empty, b_pop;
  logic                  pair_pop, b_push;
  axil_resp_t            b_resp;
  logic                  issue_ok, in_window, misaligned;
  logic                  unused_awprot;

  assign unused_awprot = ^s_axil_awprot;

  assign s_axil_awready = !aw_full && !rst;
  assign s_axil_wready  = !w_full && !rst;
  assign aw_push        = s_axil_awvalid && s_axil_awready;
  assign w_push         = s_axil_wvalid && s_axil_wready;

  assign s_axil_bvalid  = !b_empty;
  assign s_axil_bresp   = b_head;
  assign b_pop          = s_axil_bvalid && s_axil_bready;

  assign reg_wr_addr = aw_head - BASE_ADDR;
  assign reg_wr_data = w_head[WFifoW-1:STRB_WIDTH];
  assign reg_wr_strb = w_head[STRB_WIDTH-1:0];

  always_comb begin
    issue_ok   = !rst && !aw_empty && !w_empty && !b_full;
    in_window  = addr_in_window(64'(aw_head), 64'(BASE_ADDR), 64'(ADDR_SPAN));
    misaligned = (aw_head & AlignMask) != '0;
    reg_wr_en  = 1'b0;
    pair_pop   = 1'b0;
    b_push     = 1'b0;
    b_resp     = OKAY;
    if (issue_ok) begin
      if (!in_window) begin
        pair_pop = 1'b1;
        b_push   = 1'b1;
        b_resp   = DECERR;
      end else if (misaligned) begin
        pair_pop = 1'b1;
        b_push   = 1'b1;
        b_resp   = SLVERR;
      end else begin
        reg_wr_en = 1'b1;
        if (reg_wr_ready) begin
          pair_pop = 1'b1;
          b_push   = 1'b1;
          b_resp   = reg_wr_okay ? OKAY : SLVERR;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (aw_push),
    .push_data_i (s_axil_awaddr),
    .pop_i       (pair_pop),
    .head_o      (aw_head),
    .full_o      (aw_full),
    .empty_o     (aw_empty)
  );

  sync_fifo #(
    .WIDTH (WFifoW),
    .DEPTH (W_DEPTH)
  ) u_w_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (w_push),
    .push_data_i ({s_axil_wdata, s_axil_wstrb}),
    .pop_i       (pair_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  sync_fifo #(
    .WIDTH (2),
    .DEPTH (B_DEPTH)
  ) u_b_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (b_push),
    .push_data_i (b_resp),
    .pop_i       (b_pop),
    .head_o      (b_head),
    .full_o      (b_full),
    .empty_o     (b_empty)
  );

endmodule
